// File: rtl/exception_pipe_n.sv
// exception_pipe_n: carries an exception record alongside the pipeline to commit,
// keeping the oldest detection, with per-stage flush and an optional late commit source.
module exception_pipe_n #(
   parameter int STAGES  = 2,
   parameter int CAUSE_W = 5,
   parameter int TVAL_W  = 32,
   parameter bit LATE_EN = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst_sync,
   input  logic                          stall_n,
   input  logic [STAGES-1:0]             flush,
   input  logic [STAGES:0]               src_raise,
   input  logic [(STAGES+1)*CAUSE_W-1:0] src_cause,
   input  logic [(STAGES+1)*TVAL_W-1:0]  src_tval,
   output logic                          commit_raise,
   output logic [CAUSE_W-1:0]            commit_cause,
   output logic [TVAL_W-1:0]             commit_tval,
   output logic                          pending
);
   localparam int L = STAGES - 1;
   logic [STAGES-1:0]  raise_q, raise_d;
   logic [CAUSE_W-1:0] cause_q [STAGES];
   logic [CAUSE_W-1:0] cause_d [STAGES];
   logic [TVAL_W-1:0]  tval_q  [STAGES];
   logic [TVAL_W-1:0]  tval_d  [STAGES];
   logic               late;
   always_comb begin
      raise_d[0] = src_raise[0];
      cause_d[0] = src_cause[CAUSE_W-1:0];
      tval_d[0]  = src_tval[TVAL_W-1:0];
      for (int i = 1; i < STAGES; i++) begin
         raise_d[i] = raise_q[i-1] | src_raise[i];
         cause_d[i] = raise_q[i-1] ? cause_q[i-1] : src_cause[i*CAUSE_W +: CAUSE_W];
         tval_d[i]  = raise_q[i-1] ? tval_q[i-1] : src_tval[i*TVAL_W +: TVAL_W];
      end
   end
   // flush is per register, so a neighbour still captures the pre-flush contents
   always_ff @(posedge clk) begin
      for (int i = 0; i < STAGES; i++) begin
         if (rst_sync || flush[i]) begin
            raise_q[i] <= 1'b0;
            cause_q[i] <= '0;
            tval_q[i]  <= '0;
         end else if (stall_n) begin
            raise_q[i] <= raise_d[i];
            cause_q[i] <= cause_d[i];
            tval_q[i]  <= tval_d[i];
         end
      end
   end
   assign late         = LATE_EN && src_raise[STAGES];
   assign commit_raise = raise_q[L] || late;
   assign commit_cause = raise_q[L] ? cause_q[L] : late ? src_cause[STAGES*CAUSE_W +: CAUSE_W] : '0;
   assign commit_tval  = raise_q[L] ? tval_q[L] : late ? src_tval[STAGES*TVAL_W +: TVAL_W] : '0;
   assign pending      = |raise_q;
endmodule

// File: tb/tb_exception_pipe_n.sv
// tb_exception_pipe_n: scoreboard bench for exception_pipe_n in three configurations
// (2 stages with late source, 3 stages with late source, 1 stage without late source).
module tb_exception_pipe_n;
   typedef struct {
      int          cyc;
      logic        r;
      logic [4:0]  c;
      logic [31:0] t;
   } exp_t;

   logic clk = 1'b0;
   logic rst, stall_n;
   logic [1:0]   a_flush;
   logic [2:0]   a_raise;
   logic [14:0]  a_cause;
   logic [95:0]  a_tval;
   logic         a_cr, a_pend;
   logic [4:0]   a_cc;
   logic [31:0]  a_ct;
   logic [2:0]   b_flush;
   logic [3:0]   b_raise;
   logic [19:0]  b_cause;
   logic [127:0] b_tval;
   logic         b_cr, b_pend;
   logic [4:0]   b_cc;
   logic [31:0]  b_ct;
   logic [0:0]   c_flush;
   logic [1:0]   c_raise;
   logic [9:0]   c_cause;
   logic [63:0]  c_tval;
   logic         c_cr, c_pend;
   logic [4:0]   c_cc;
   logic [31:0]  c_ct;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   exp_t e;

   always #5 clk = ~clk;

   exception_pipe_n #(.STAGES(2), .CAUSE_W(5), .TVAL_W(32), .LATE_EN(1'b1)) dut_a (
      .clk(clk), .rst_sync(rst), .stall_n(stall_n), .flush(a_flush),
      .src_raise(a_raise), .src_cause(a_cause), .src_tval(a_tval),
      .commit_raise(a_cr), .commit_cause(a_cc), .commit_tval(a_ct), .pending(a_pend));

   exception_pipe_n #(.STAGES(3), .CAUSE_W(5), .TVAL_W(32), .LATE_EN(1'b1)) dut_b (
      .clk(clk), .rst_sync(rst), .stall_n(stall_n), .flush(b_flush),
      .src_raise(b_raise), .src_cause(b_cause), .src_tval(b_tval),
      .commit_raise(b_cr), .commit_cause(b_cc), .commit_tval(b_ct), .pending(b_pend));

   exception_pipe_n #(.STAGES(1), .CAUSE_W(5), .TVAL_W(32), .LATE_EN(1'b0)) dut_c (
      .clk(clk), .rst_sync(rst), .stall_n(stall_n), .flush(c_flush),
      .src_raise(c_raise), .src_cause(c_cause), .src_tval(c_tval),
      .commit_raise(c_cr), .commit_cause(c_cc), .commit_tval(c_ct), .pending(c_pend));

   task automatic cycle();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic quiet();
      rst = 1'b0; stall_n = 1'b1;
      a_flush = '0; a_raise = '0; a_cause = '0; a_tval = '0;
      b_flush = '0; b_raise = '0; b_cause = '0; b_tval = '0;
      c_flush = '0; c_raise = '0; c_cause = '0; c_tval = '0;
   endtask

   function automatic void push(int at, logic [4:0] ca, logic [31:0] tv);
      exp_t x;
      x.cyc = at; x.r = 1'b1; x.c = ca; x.t = tv;
      sb.push_back(x);
   endfunction

   function automatic exp_t expect_at(int at);
      exp_t x;
      x.cyc = at; x.r = 1'b0; x.c = '0; x.t = '0;
      if (sb.size() != 0 && sb[0].cyc == at) x = sb.pop_front();
      return x;
   endfunction

   task automatic test_reset();
      quiet();
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      #1;
      checks++;
      if ({a_cr, a_cc, a_ct, a_pend} !== 39'd0) begin
         errors++; $display("FAIL reset_a got %b/%0d/%h pend %b expected all zero", a_cr, a_cc, a_ct, a_pend);
      end
      checks++;
      if ({b_cr, b_cc, b_ct, b_pend} !== 39'd0) begin
         errors++; $display("FAIL reset_b got %b/%0d/%h pend %b expected all zero", b_cr, b_cc, b_ct, b_pend);
      end
      checks++;
      if ({c_cr, c_cc, c_ct, c_pend} !== 39'd0) begin
         errors++; $display("FAIL reset_c got %b/%0d/%h pend %b expected all zero", c_cr, c_cc, c_ct, c_pend);
      end
   endtask

   task automatic test_single();
      int n = cyc;
      logic [3:0] pexp = 4'b0011;
      push(n + 2, 5'd1, 32'h100);
      for (int k = 0; k < 4; k++) begin
         if (k == 0) begin a_raise[0] = 1'b1; a_cause[4:0] = 5'd1; a_tval[31:0] = 32'h100; end
         cycle();
         quiet();
         #1;
         e = expect_at(cyc);
         checks++;
         if ({a_cr, a_cc, a_ct} !== {e.r, e.c, e.t}) begin
            errors++; $display("FAIL single cyc=%0d got %b/%0d/%h expected %b/%0d/%h", cyc, a_cr, a_cc, a_ct, e.r, e.c, e.t);
         end
         checks++;
         if (a_pend !== pexp[k]) begin
            errors++; $display("FAIL single_pending k=%0d got %b expected %b", k, a_pend, pexp[k]);
         end
      end
   endtask

   task automatic test_priority();
      int n = cyc;
      logic [4:0] pexp = 5'b01011;
      push(n + 2, 5'd1, 32'hA0);
      push(n + 4, 5'd3, 32'h33);
      for (int k = 0; k < 5; k++) begin
         case (k)
            0: begin a_raise[0] = 1'b1; a_cause[4:0] = 5'd1; a_tval[31:0] = 32'hA0; end
            1: begin a_raise[1] = 1'b1; a_cause[9:5] = 5'd2; a_tval[63:32] = 32'hB0; end
            3: begin a_raise[1] = 1'b1; a_cause[9:5] = 5'd3; a_tval[63:32] = 32'h33; end
            default: ;
         endcase
         cycle();
         quiet();
         #1;
         e = expect_at(cyc);
         checks++;
         if ({a_cr, a_cc, a_ct} !== {e.r, e.c, e.t}) begin
            errors++; $display("FAIL priority cyc=%0d got %b/%0d/%h expected %b/%0d/%h", cyc, a_cr, a_cc, a_ct, e.r, e.c, e.t);
         end
         checks++;
         if (a_pend !== pexp[k]) begin
            errors++; $display("FAIL priority_pending k=%0d got %b expected %b", k, a_pend, pexp[k]);
         end
      end
   endtask

   task automatic test_stall();
      int n = cyc;
      logic [7:0] pexp = 8'b01111111;
      push(n + 7, 5'd12, 32'hC12);
      for (int k = 0; k < 8; k++) begin
         if (k == 0) begin
            a_raise[0] = 1'b1; a_cause[4:0] = 5'd12; a_tval[31:0] = 32'hC12;
         end else if (k <= 5) begin
            stall_n = 1'b0;
            a_raise[1:0] = 2'b11; a_cause[9:0] = {5'd6, 5'd5}; a_tval[63:0] = {32'h66, 32'h55};
         end
         cycle();
         quiet();
         #1;
         e = expect_at(cyc);
         checks++;
         if ({a_cr, a_cc, a_ct} !== {e.r, e.c, e.t}) begin
            errors++; $display("FAIL stall cyc=%0d got %b/%0d/%h expected %b/%0d/%h", cyc, a_cr, a_cc, a_ct, e.r, e.c, e.t);
         end
         checks++;
         if (a_pend !== pexp[k]) begin
            errors++; $display("FAIL stall_pending k=%0d got %b expected %b", k, a_pend, pexp[k]);
         end
      end
   endtask

   task automatic test_flush_stall();
      int n = cyc;
      logic [8:0] pexp = 9'b011110001;
      push(n + 6, 5'd6, 32'h66);
      push(n + 8, 5'd7, 32'h77);
      for (int k = 0; k < 9; k++) begin
         case (k)
            0: begin a_raise[0] = 1'b1; a_cause[4:0] = 5'd4; a_tval[31:0] = 32'h44; end
            1: begin stall_n = 1'b0; a_flush = 2'b01; end
            4: begin a_raise[0] = 1'b1; a_cause[4:0] = 5'd6; a_tval[31:0] = 32'h66; end
            6: begin a_flush = 2'b10; a_raise[0] = 1'b1; a_cause[4:0] = 5'd7; a_tval[31:0] = 32'h77; end
            default: ;
         endcase
         cycle();
         quiet();
         #1;
         e = expect_at(cyc);
         checks++;
         if ({a_cr, a_cc, a_ct} !== {e.r, e.c, e.t}) begin
            errors++; $display("FAIL flush_stall cyc=%0d got %b/%0d/%h expected %b/%0d/%h", cyc, a_cr, a_cc, a_ct, e.r, e.c, e.t);
         end
         checks++;
         if (a_pend !== pexp[k]) begin
            errors++; $display("FAIL flush_stall_pending k=%0d got %b expected %b", k, a_pend, pexp[k]);
         end
      end
   endtask

   task automatic test_late();
      int n = cyc;
      logic [3:0] pexp = 4'b0011;
      a_raise[2] = 1'b1; a_cause[14:10] = 5'd7; a_tval[95:64] = 32'hDEADBEEF;
      #1;
      checks++;
      if ({a_cr, a_cc, a_ct} !== {1'b1, 5'd7, 32'hDEADBEEF}) begin
         errors++; $display("FAIL late_comb got %b/%0d/%h expected 1/7/deadbeef", a_cr, a_cc, a_ct);
      end
      push(n + 1, 5'd7, 32'hDEADBEEF);
      push(n + 2, 5'd9, 32'h99);
      push(n + 3, 5'd7, 32'hDEADBEEF);
      for (int k = 0; k < 4; k++) begin
         if (k == 0) begin a_raise[0] = 1'b1; a_cause[4:0] = 5'd9; a_tval[31:0] = 32'h99; end
         if (k == 3) quiet();
         cycle();
         a_raise[0] = 1'b0;
         #1;
         e = expect_at(cyc);
         checks++;
         if ({a_cr, a_cc, a_ct} !== {e.r, e.c, e.t}) begin
            errors++; $display("FAIL late cyc=%0d got %b/%0d/%h expected %b/%0d/%h", cyc, a_cr, a_cc, a_ct, e.r, e.c, e.t);
         end
         checks++;
         if (a_pend !== pexp[k]) begin
            errors++; $display("FAIL late_pending k=%0d got %b expected %b", k, a_pend, pexp[k]);
         end
      end
   endtask

   task automatic test_flush_partial();
      int n = cyc;
      logic [10:0] pexp = 11'b00111001111;
      push(n + 3, 5'd1, 32'h11);
      push(n + 4, 5'd2, 32'h22);
      push(n + 9, 5'd1, 32'h11);
      for (int k = 0; k < 11; k++) begin
         case (k)
            0, 6: begin b_raise[0] = 1'b1; b_cause[4:0] = 5'd1; b_tval[31:0] = 32'h11; end
            1, 7: begin b_raise[0] = 1'b1; b_cause[4:0] = 5'd2; b_tval[31:0] = 32'h22; end
            2: begin b_flush = 3'b001; b_raise[0] = 1'b1; b_cause[4:0] = 5'd5; b_tval[31:0] = 32'h55; end
            8: b_flush = 3'b010;
            default: ;
         endcase
         cycle();
         quiet();
         #1;
         e = expect_at(cyc);
         checks++;
         if ({b_cr, b_cc, b_ct} !== {e.r, e.c, e.t}) begin
            errors++; $display("FAIL flush_partial cyc=%0d got %b/%0d/%h expected %b/%0d/%h", cyc, b_cr, b_cc, b_ct, e.r, e.c, e.t);
         end
         checks++;
         if (b_pend !== pexp[k]) begin
            errors++; $display("FAIL flush_partial_pending k=%0d got %b expected %b", k, b_pend, pexp[k]);
         end
      end
   endtask

   task automatic test_late_disabled();
      int n = cyc;
      logic [1:0] pexp = 2'b01;
      c_raise[1] = 1'b1; c_cause[9:5] = 5'd7; c_tval[63:32] = 32'hBEEF;
      #1;
      checks++;
      if ({c_cr, c_cc, c_ct} !== 38'd0) begin
         errors++; $display("FAIL late_disabled got %b/%0d/%h expected 0/0/0", c_cr, c_cc, c_ct);
      end
      push(n + 1, 5'd3, 32'h3);
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin c_raise[0] = 1'b1; c_cause[4:0] = 5'd3; c_tval[31:0] = 32'h3; end
         cycle();
         c_raise[0] = 1'b0;
         #1;
         e = expect_at(cyc);
         checks++;
         if ({c_cr, c_cc, c_ct} !== {e.r, e.c, e.t}) begin
            errors++; $display("FAIL one_stage cyc=%0d got %b/%0d/%h expected %b/%0d/%h", cyc, c_cr, c_cc, c_ct, e.r, e.c, e.t);
         end
         checks++;
         if (c_pend !== pexp[k]) begin
            errors++; $display("FAIL one_stage_pending k=%0d got %b expected %b", k, c_pend, pexp[k]);
         end
      end
      quiet();
   endtask

   task automatic test_reset_mid();
      int n = cyc;
      logic [5:0] pexp = 6'b011011;
      push(n + 2, 5'd3, 32'h3);
      push(n + 5, 5'd8, 32'h8);
      for (int k = 0; k < 6; k++) begin
         case (k)
            0: begin a_raise[0] = 1'b1; a_cause[4:0] = 5'd3; a_tval[31:0] = 32'h3; end
            1: begin a_raise[0] = 1'b1; a_cause[4:0] = 5'd4; a_tval[31:0] = 32'h4; end
            2: rst = 1'b1;
            3: begin a_raise[0] = 1'b1; a_cause[4:0] = 5'd8; a_tval[31:0] = 32'h8; end
            default: ;
         endcase
         cycle();
         quiet();
         #1;
         e = expect_at(cyc);
         checks++;
         if ({a_cr, a_cc, a_ct} !== {e.r, e.c, e.t}) begin
            errors++; $display("FAIL reset_mid cyc=%0d got %b/%0d/%h expected %b/%0d/%h", cyc, a_cr, a_cc, a_ct, e.r, e.c, e.t);
         end
         checks++;
         if (a_pend !== pexp[k]) begin
            errors++; $display("FAIL reset_mid_pending k=%0d got %b expected %b", k, a_pend, pexp[k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_priority();
      test_stall();
      test_flush_stall();
      test_late();
      test_flush_partial();
      test_late_disabled();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain got %0d entries left expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
